// File: rtl/cordic_lut_loader.sv
// Loads the cordic_rom lookup table from a valid/ready word stream. Each group of
// WPE words becomes one entry; a trailing checksum word sets err once the table is full.
module cordic_lut_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 48,
  parameter int BUS_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [BUS_W-1:0]  s_data,
  output logic              s_ready,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] index_wri,
  output logic [DATA_W-1:0] D,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WPE   = DATA_W / BUS_W;
  localparam int CNT_W = $clog2(WPE + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, FIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   word_cnt;
  logic [BUS_W-1:0]   csum;
  logic               take;
  logic               last_word;
  logic               start_ok;

  // Running checksum wraps modulo 2**BUS_W.
  function automatic logic [BUS_W-1:0] wrap_add(input logic [BUS_W-1:0] a,
                                                 input logic [BUS_W-1:0] b);
    return a + b;
  endfunction

  assign s_ready   = (state == COLLECT) || (state == CHECK);
  assign take      = s_valid && s_ready;
  assign last_word = (word_cnt == CNT_W'(WPE - 1));
  assign start_ok  = start && ((state == IDLE) || (state == FIN));
  assign cen       = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wen       = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (take && last_word) state_nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        wen  = 1'b0;
        state_nxt = (index_wri == LAST_IDX) ? CHECK : COLLECT;
      end
      CHECK: begin
        busy = 1'b1;
        if (take) state_nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start_ok) state_nxt = COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Entry assembly, write address and checksum; all cleared by an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_wri <= '0;
      D         <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      err       <= 1'b0;
    end else if (start_ok) begin
      index_wri <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      err       <= 1'b0;
    end else begin
      if ((state == COLLECT) && take) begin
        D        <= (D << BUS_W) | DATA_W'(s_data);
        csum     <= wrap_add(csum, s_data);
        word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
      end
      if ((state == WRITE) && (index_wri != LAST_IDX))
        index_wri <= index_wri + ADDR_W'(1);
      if ((state == CHECK) && take)
        err <= (s_data != csum);
    end
  end

endmodule

// File: doc/cordic_lut_loader.md
Name: cordic_lut_loader

Overview:
- Upstream feeder for cordic_rom.
- Accepts a 16-bit word stream over a valid/ready handshake.
- Assembles each group of words into one 48-bit LUT entry and writes it into cordic_rom's 64-entry table through the wen/index_wri/D write port.
- After all entries are written, checks a trailing checksum word and reports done/err, so the synthesizer can be released to run.

Parameters:
- ADDR_W, 6: LUT address width; entry count = 2**ADDR_W.
- DATA_W, 48: LUT entry width; must be an integer multiple of BUS_W.
- BUS_W, 16: stream word width; WPE = DATA_W/BUS_W words per entry (3 by default).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load when the block is idle or done.
- s_valid  input  1  stream word valid.
- s_data  input  BUS_W  stream word; most-significant word of each entry first.
- s_ready  output  1  block can accept s_data this cycle.
- cen  output  1  ROM chip enable, active-low.
- wen  output  1  ROM write enable, active-low; low for exactly one cycle per entry.
- index_wri  output  ADDR_W  ROM write address.
- D  output  DATA_W  ROM write data.
- busy  output  1  load in progress.
- done  output  1  load finished; sticky until the next accepted start or reset.
- err  output  1  checksum mismatch on the last load; valid while done=1.

Behaviour:
- Reset (asynchronous, reset=0) values: state=IDLE, s_ready=0, cen=0, wen=1, index_wri=0, D=0, busy=0, done=0, err=0, word counter=0, checksum=0.
- States: IDLE, COLLECT, WRITE, CHECK, FIN.
- IDLE/FIN + start=1:
  - go to COLLECT; clear index_wri, word counter, checksum, done and err.
  - busy=1 from the next cycle.
- start in any other state is ignored.
- COLLECT:
  - s_ready=1.
  - On s_valid&s_ready, shift s_data into D from the LSB end (D <= {D[DATA_W-BUS_W-1:0], s_data}); add s_data to the checksum mod 2**BUS_W; increment the word counter.
  - The WPE-th accepted word moves to WRITE on the next edge; the word counter resets to 0.
- WRITE:
  - Exactly one cycle; wen=0, s_ready=0.
  - index_wri and D are stable the whole cycle; the ROM samples them on the closing edge.
  - On exit, wen=1.
  - If index_wri == 2**ADDR_W-1, go to CHECK and leave index_wri at 63. Otherwise increment index_wri and return to COLLECT.
- CHECK:
  - s_ready=1; the next accepted word is the expected checksum.
  - On acceptance, err <= (s_data != checksum); go to FIN.
  - The checksum word is not added to the checksum.
- FIN: done=1, busy=0, s_ready=0, wen=1; D and index_wri hold their last values.
- Words presented while s_ready=0 are not consumed (s_valid is not stalled or dropped by the block; the source must hold).
- s_valid gaps of any length in COLLECT/CHECK simply stall; no timeout.
- Minimum load time after start: 64*(WPE+1)+1 words/cycles. That is 257 cycles of transfer plus the start cycle at full rate with WPE=3.
- cen is held 0 at all times after reset (ROM always enabled).
- wen is never 0 outside WRITE.
- Reset mid-load: all state is discarded immediately. The ROM keeps any entries already written, but done=0, so the consumer must not trust the table.
- The index_wri wrap from 63 to 0 never occurs within one load.

Test Plan:
- Reset with reset=0 for 3 cycles, then release -> wen=1, cen=0, busy=0, done=0, err=0, s_ready=0, index_wri=0.
- start, then 192 back-to-back words with value k (k=0..191), then checksum 0x47A0 (sum of 0..191 = 18336):
  - Exactly 64 single-cycle wen=0 pulses.
  - Entry n has D = {3n, 3n+1, 3n+2}; entry 0 = 0x000000010002, entry 63 = 0x00BD00BE00BF.
  - index_wri = 0..63 in order.
  - done=1, err=0, busy=0 at the end.
- Same stream with s_valid deasserted randomly 50% of cycles -> identical write sequence and D values; no wen pulse while fewer than 3 words are collected.
- Same stream with checksum 0x47A1 -> 64 writes still occur; done=1, err=1.
- start pulsed during entry 10 of a load -> ignored: index_wri continues at 10, and the load completes normally.
- reset=0 asserted during WRITE of entry 20:
  - wen returns to 1 asynchronously; all outputs return to reset values.
  - A new start and full stream then completes with done=1, err=0.
